// File: rtl/framebuffer_pkg.sv
// Shared state encoding and defaults for the framebuffer SRAM sequencer.
package framebuffer_pkg;

    localparam int FB_ADDR_W       = 20;
    localparam int FB_DATA_W       = 16;
    localparam int FB_FRAME_WORDS  = 76800;
    localparam int FB_WAIT_STATES  = 1;

    localparam logic [15:0] TP_XOR = 16'hA5A5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP_WAIT,
        ST_CAP_SETUP,
        ST_CAP_STROBE,
        ST_RD_WAIT,
        ST_RD_STROBE
    } fb_state_t;

endpackage

// File: rtl/sram_cycle_timer.sv
// Strobe-length timer shared by the SRAM write and read paths.
module sram_cycle_timer #(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last_cycle
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_STATES + 1);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign last_cycle = (cnt == 4'd1);

endmodule

// File: rtl/fb_sram_sequencer.sv
// Framebuffer SRAM sequencer: camera capture writes and SPI readout reads.
// Define FB_TEST_PATTERN_EN to replace the pixel path with an address-derived pattern.
module fb_sram_sequencer
    import framebuffer_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int FRAME_WORDS = FB_FRAME_WORDS,
    parameter int WAIT_STATES = FB_WAIT_STATES
) (
    input  logic              SYSCLK,
    input  logic              RESET,
    input  logic              CAPTURE_READ,
    input  logic              START,
    input  logic              ABORT,
    input  logic              PIX_VALID,
    input  logic [DATA_W-1:0] PIX_DATA,
    input  logic              RD_REQ,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [DATA_W-1:0] SRAM_DQ_O,
    input  logic [DATA_W-1:0] SRAM_DQ_I,
    output logic              SRAM_DQ_OE,
    output logic              SRAM_CE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              BUSY,
    output logic              CAPTURE_COMPLETE,
    output logic              READ_COMPLETE,
    output logic              OVERRUN
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    fb_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, addr_inc;
    logic [DATA_W-1:0] wr_data, wr_data_nxt;
    logic [DATA_W-1:0] rd_data, rd_data_nxt;
    logic              rd_valid, rd_valid_nxt;
    logic              cap_done, cap_done_nxt;
    logic              rd_done, rd_done_nxt;
    logic              overrun, overrun_nxt;
    logic              timer_load, timer_last;

`ifndef FB_TEST_PATTERN_EN
    logic              hold_full, hold_full_nxt;
    logic [DATA_W-1:0] hold_data, hold_data_nxt;
    logic              hold_take, pix_take, capturing;

    assign capturing = state inside {ST_CAP_WAIT, ST_CAP_SETUP, ST_CAP_STROBE};
`else
    logic unused_pix;
    assign unused_pix = ^{PIX_VALID, PIX_DATA};
`endif

    assign addr_inc = addr + ADDR_W'(1);

    sram_cycle_timer #(
        .WAIT_STATES(WAIT_STATES)
    ) u_timer (
        .clk       (SYSCLK),
        .rst       (RESET),
        .load      (timer_load),
        .last_cycle(timer_last)
    );

    always_ff @(posedge SYSCLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        wr_data_nxt  = wr_data;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = 1'b0;
        cap_done_nxt = 1'b0;
        rd_done_nxt  = 1'b0;
        overrun_nxt  = overrun;
        timer_load   = 1'b0;
`ifndef FB_TEST_PATTERN_EN
        hold_full_nxt = hold_full;
        hold_data_nxt = hold_data;
        hold_take     = 1'b0;
        pix_take      = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    state_nxt   = CAPTURE_READ ? ST_CAP_WAIT : ST_RD_WAIT;
                    addr_nxt    = '0;
                    overrun_nxt = 1'b0;
                end
            end
            ST_CAP_WAIT: begin
`ifdef FB_TEST_PATTERN_EN
                state_nxt   = ST_CAP_SETUP;
                wr_data_nxt = DATA_W'(addr) ^ DATA_W'(TP_XOR);
`else
                if (hold_full) begin
                    hold_take   = 1'b1;
                    wr_data_nxt = hold_data;
                    state_nxt   = ST_CAP_SETUP;
                end else if (PIX_VALID) begin
                    pix_take    = 1'b1;
                    wr_data_nxt = PIX_DATA;
                    state_nxt   = ST_CAP_SETUP;
                end
`endif
            end
            ST_CAP_SETUP: begin
                state_nxt  = ST_CAP_STROBE;
                timer_load = 1'b1;
            end
            ST_CAP_STROBE: begin
                if (timer_last) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt    = ST_IDLE;
                        addr_nxt     = '0;
                        cap_done_nxt = 1'b1;
                    end else begin
                        addr_nxt = addr_inc;
`ifdef FB_TEST_PATTERN_EN
                        state_nxt   = ST_CAP_SETUP;
                        wr_data_nxt = DATA_W'(addr_inc) ^ DATA_W'(TP_XOR);
`else
                        // A held pixel goes straight into the next write.
                        if (hold_full) begin
                            hold_take   = 1'b1;
                            wr_data_nxt = hold_data;
                            state_nxt   = ST_CAP_SETUP;
                        end else begin
                            state_nxt = ST_CAP_WAIT;
                        end
`endif
                    end
                end
            end
            ST_RD_WAIT: begin
                if (RD_REQ) begin
                    state_nxt  = ST_RD_STROBE;
                    timer_load = 1'b1;
                end
            end
            ST_RD_STROBE: begin
                if (timer_last) begin
                    rd_data_nxt  = SRAM_DQ_I;
                    rd_valid_nxt = 1'b1;
                    if (addr == LAST_ADDR) begin
                        state_nxt   = ST_IDLE;
                        addr_nxt    = '0;
                        rd_done_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RD_WAIT;
                        addr_nxt  = addr_inc;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (ABORT && state != ST_IDLE) begin
            state_nxt    = ST_IDLE;
            addr_nxt     = '0;
            rd_valid_nxt = 1'b0;
            cap_done_nxt = 1'b0;
            rd_done_nxt  = 1'b0;
            timer_load   = 1'b0;
        end

`ifndef FB_TEST_PATTERN_EN
        if (hold_take) hold_full_nxt = 1'b0;
        if (capturing && PIX_VALID && !pix_take) begin
            if (hold_full && !hold_take) begin
                overrun_nxt = 1'b1;
            end else begin
                hold_full_nxt = 1'b1;
                hold_data_nxt = PIX_DATA;
            end
        end
        if (state_nxt == ST_IDLE) hold_full_nxt = 1'b0;
`endif
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            addr     <= '0;
            wr_data  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            cap_done <= 1'b0;
            rd_done  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            addr     <= addr_nxt;
            wr_data  <= wr_data_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
            cap_done <= cap_done_nxt;
            rd_done  <= rd_done_nxt;
            overrun  <= overrun_nxt;
        end
    end

`ifndef FB_TEST_PATTERN_EN
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_full <= hold_full_nxt;
            hold_data <= hold_data_nxt;
        end
    end
`endif

    assign SRAM_CE_N  = !(state inside {ST_CAP_SETUP, ST_CAP_STROBE, ST_RD_STROBE});
    assign SRAM_WE_N  = (state != ST_CAP_STROBE);
    assign SRAM_OE_N  = (state != ST_RD_STROBE);
    assign SRAM_DQ_OE = (state inside {ST_CAP_SETUP, ST_CAP_STROBE});
    assign SRAM_ADDR  = addr;
    assign SRAM_DQ_O  = wr_data;

    assign RD_DATA          = rd_data;
    assign RD_VALID         = rd_valid;
    assign BUSY             = (state != ST_IDLE);
    assign CAPTURE_COMPLETE = cap_done;
    assign READ_COMPLETE    = rd_done;
    assign OVERRUN          = overrun;

endmodule

// File: tb/tb_fb_sram_sequencer.sv
// Self-checking bench for fb_sram_sequencer with an 8-word frame and one wait state.
module tb_fb_sram_sequencer;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int WS = 1;

    logic          SYSCLK = 1'b0;
    logic          RESET, CAPTURE_READ, START, ABORT, PIX_VALID, RD_REQ;
    logic [DW-1:0] PIX_DATA, RD_DATA, SRAM_DQ_O, SRAM_DQ_I;
    logic          RD_VALID, SRAM_DQ_OE, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;
    logic          BUSY, CAPTURE_COMPLETE, READ_COMPLETE, OVERRUN;
    logic [AW-1:0] SRAM_ADDR;

    fb_sram_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .WAIT_STATES(WS)
    ) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .CAPTURE_READ(CAPTURE_READ),
        .START(START), .ABORT(ABORT), .PIX_VALID(PIX_VALID),
        .PIX_DATA(PIX_DATA), .RD_REQ(RD_REQ), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O),
        .SRAM_DQ_I(SRAM_DQ_I), .SRAM_DQ_OE(SRAM_DQ_OE),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
        .BUSY(BUSY), .CAPTURE_COMPLETE(CAPTURE_COMPLETE),
        .READ_COMPLETE(READ_COMPLETE), .OVERRUN(OVERRUN)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {logic [DW-1:0] pix; logic [AW-1:0] addr;} cap_vec_t;
    typedef struct {int len; int gap; logic [DW-1:0] data;} rd_vec_t;
    typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_exp_t;
    typedef struct {logic [DW-1:0] data; int cyc; logic last;} rd_exp_t;

    cap_vec_t cap_tab[FW];
    rd_vec_t  rd_tab[FW];
    wr_exp_t  wq[$];
    rd_exp_t  rq[$];

    logic [DW-1:0] mem [16];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, cc_cnt = 0, rc_cnt = 0, we_len = 0, t0 = 0;
    bit wr_sb_en = 1'b1, len_chk = 1'b1;

    assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[3:0]] : 16'hDEAD;

    always @(posedge SYSCLK) begin
        cyc <= cyc + 1;
        if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[3:0]] = SRAM_DQ_O;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYSCLK);
            #1;
        end
    endtask

    task automatic start_op(input logic cap);
        CAPTURE_READ = cap;
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic send_pix(input logic [DW-1:0] d, input int gap);
        PIX_VALID = 1'b1;
        PIX_DATA  = d;
        tick(1);
        PIX_VALID = 1'b0;
        tick(gap);
    endtask

    // Write scoreboard pops on the first strobe cycle; read one on RD_VALID.
    always @(negedge SYSCLK) begin
        wr_exp_t w;
        rd_exp_t r;
        if (!SRAM_WE_N) begin
            check("wr_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_DQ_OE}, 3'b011);
            if (we_len == 0 && wr_sb_en) begin
                check("wr_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("wr_addr", SRAM_ADDR, w.addr);
                    check("wr_data", SRAM_DQ_O, w.data);
                end
            end
            we_len++;
        end else begin
            if (we_len != 0 && len_chk) check("we_len", we_len, WS + 1);
            we_len = 0;
        end
        if (!SRAM_OE_N) check("rd_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE}, 3'b010);
        if (RD_VALID) begin
            check("rd_expected", rq.size() > 0, 1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                check("rd_data", RD_DATA, r.data);
                check("rd_latency", cyc - r.cyc, WS + 2);
                check("rd_complete", READ_COMPLETE, r.last);
            end
        end else if (READ_COMPLETE) begin
            check("rd_complete_stray", READ_COMPLETE, 0);
        end
        if (CAPTURE_COMPLETE) cc_cnt++;
        if (READ_COMPLETE) rc_cnt++;
    end

    initial begin
        RESET = 1'b1; CAPTURE_READ = 1'b0; START = 1'b0; ABORT = 1'b0;
        PIX_VALID = 1'b0; PIX_DATA = '0; RD_REQ = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick(3);
        check("rst_busy", BUSY, 0);
        check("rst_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 4'b1110);
        check("rst_addr", SRAM_ADDR, 0);
        check("rst_rd", {RD_DATA, RD_VALID}, 0);
        check("rst_flags", {CAPTURE_COMPLETE, READ_COMPLETE, OVERRUN}, 0);
        RESET = 1'b0;
        tick(1);

`ifdef FB_TEST_PATTERN_EN
        wr_sb_en = 1'b0;
        start_op(1'b1);
        t0 = cyc;
        check("tp_busy", BUSY, 1);
        for (int i = 0; i < 3; i++) send_pix(16'hFFFF, 0);
        for (int i = 0; i < 60 && !CAPTURE_COMPLETE; i++) tick(1);
        check("tp_cc_latency", cyc - t0, FW * (WS + 2) + 1);
        check("tp_mem5", mem[5], 16'hA5A0);
        for (int k = 0; k < FW; k++) check("tp_mem", mem[k], 16'(k) ^ 16'hA5A5);
        tick(2);
        check("tp_overrun", OVERRUN, 0);
        check("tp_busy_end", BUSY, 0);
        check("tp_cc_cnt", cc_cnt, 1);
`else
        // Capture: one pixel every 4 cycles.
        for (int i = 0; i < FW; i++) cap_tab[i] = '{pix: 16'(i + 1), addr: AW'(i)};
        cc_cnt = 0;
        start_op(1'b1);
        for (int i = 0; i < FW; i++) begin
            wq.push_back('{cap_tab[i].addr, cap_tab[i].pix});
            send_pix(cap_tab[i].pix, 3);
        end
        for (int i = 0; i < 20 && cc_cnt == 0; i++) tick(1);
        tick(2);
        check("cap_cc_cnt", cc_cnt, 1);
        check("cap_overrun", OVERRUN, 0);
        check("cap_busy", BUSY, 0);
        check("cap_addr", SRAM_ADDR, 0);
        for (int i = 0; i < FW; i++) check("cap_mem", mem[cap_tab[i].addr[3:0]], cap_tab[i].pix);

        // Readout: entry 2 holds RD_REQ into the strobe, which must be ignored.
        for (int i = 0; i < FW; i++) begin
            mem[i] = 16'h1000 + 16'(i);
            rd_tab[i] = '{len: (i == 2) ? 2 : 1, gap: (i % 3 == 0) ? 2 : 4,
                          data: 16'h1000 + 16'(i)};
        end
        rc_cnt = 0;
        start_op(1'b0);
        for (int i = 0; i < FW; i++) begin
            rq.push_back('{rd_tab[i].data, cyc, i == FW - 1});
            RD_REQ = 1'b1;
            tick(rd_tab[i].len);
            RD_REQ = 1'b0;
            tick(rd_tab[i].gap);
        end
        tick(3);
        check("rd_queue_empty", rq.size(), 0);
        check("rd_cmpl_cnt", rc_cnt, 1);
        check("rd_busy", BUSY, 0);

        // Overrun: three back-to-back pixels, third dropped.
        start_op(1'b1);
        wq.push_back('{AW'(0), 16'hC0A0});
        wq.push_back('{AW'(1), 16'hC0B0});
        PIX_VALID = 1'b1;
        PIX_DATA = 16'hC0A0; tick(1);
        PIX_DATA = 16'hC0B0; tick(1);
        PIX_DATA = 16'hC0C0; tick(1);
        PIX_VALID = 1'b0;
        tick(8);
        check("ovr_flag", OVERRUN, 1);
        check("ovr_mem0", mem[0], 16'hC0A0);
        check("ovr_mem1", mem[1], 16'hC0B0);
        check("ovr_mem2", mem[2], 16'h1002);
        check("ovr_addr", SRAM_ADDR, 2);
        ABORT = 1'b1; tick(1); ABORT = 1'b0;
        check("ovr_abort_busy", BUSY, 0);
        check("ovr_sticky", OVERRUN, 1);
        start_op(1'b0);
        check("ovr_cleared", OVERRUN, 0);
        check("ovr_rd_busy", BUSY, 1);
        ABORT = 1'b1; tick(1); ABORT = 1'b0;

        // ABORT beats START in IDLE.
        CAPTURE_READ = 1'b1; START = 1'b1; ABORT = 1'b1;
        tick(1);
        START = 1'b0; ABORT = 1'b0;
        check("abort_start_busy", BUSY, 0);

        // ABORT after the third capture write.
        for (int i = 0; i < FW; i++) mem[i] = 16'hEEEE;
        cc_cnt = 0;
        start_op(1'b1);
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{AW'(i), 16'h0A01 + 16'(i)});
            send_pix(16'h0A01 + 16'(i), 3);
        end
        ABORT = 1'b1; tick(1); ABORT = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_addr", SRAM_ADDR, 0);
        check("abort_strobes", {SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE}, 4'b1110);
        tick(3);
        check("abort_no_cc", cc_cnt, 0);
        for (int i = 0; i < 3; i++) check("abort_mem_written", mem[i], 16'h0A01 + 16'(i));
        for (int i = 3; i < FW; i++) check("abort_mem_untouched", mem[i], 16'hEEEE);
        start_op(1'b1);
        wq.push_back('{AW'(0), 16'h0B00});
        send_pix(16'h0B00, 3);
        check("restart_mem0", mem[0], 16'h0B00);
        check("restart_addr", SRAM_ADDR, 1);
        ABORT = 1'b1; tick(1); ABORT = 1'b0;

        // Reset in the middle of a write strobe.
        start_op(1'b1);
        wq.push_back('{AW'(0), 16'h0D00});
        send_pix(16'h0D00, 1);
        check("rms_in_strobe", SRAM_WE_N, 0);
        len_chk = 1'b0;
        RESET = 1'b1; tick(1); RESET = 1'b0;
        check("rms_we_n", SRAM_WE_N, 1);
        check("rms_ce_n", SRAM_CE_N, 1);
        check("rms_busy", BUSY, 0);
        check("rms_addr", SRAM_ADDR, 0);
        tick(1);
        len_chk = 1'b1;
        check("wr_queue_empty", wq.size(), 0);
`endif
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
